// File: rtl/tag_freelist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tag_freelist_pkg
// Description : Shared constants, types and helper functions for the
//               multi-port rename-tag free list.
// Revision    : 1.0 - initial release
// ============================================================================
package tag_freelist_pkg;

  localparam int TAG_W_DEF       = 6;
  localparam int NUM_TAGS_DEF    = 64;
  localparam int ALLOC_PORTS_DEF = 2;
  localparam int REL_PORTS_DEF   = 2;

  // Widest port vector the helpers accept, and the width of a per-port
  // write offset / count (0..MAX_PORTS).
  localparam int MAX_PORTS = 4;
  localparam int OFF_W     = 3;

  typedef logic [TAG_W_DEF-1:0] tag_t;
  typedef logic [MAX_PORTS-1:0] port_vec_t;

  // (ptr + inc) mod n using subtraction, so n need not be a power of two.
  // ptr < n and inc <= MAX_PORTS, so a few conditional subtractions suffice.
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned n);
    int unsigned s;
    s = ptr + inc;
    for (int k = 0; k <= MAX_PORTS; k++) begin
      if (s >= n) s = s - n;
    end
    return s;
  endfunction

  // Number of consecutive ones starting at bit 0.
  function automatic int unsigned leading_ones(input port_vec_t vec);
    int unsigned c;
    logic        run;
    c   = 0;
    run = 1'b1;
    for (int i = 0; i < MAX_PORTS; i++) begin
      run = run & vec[i];
      if (run) c = c + 1;
    end
    return c;
  endfunction

  // Number of set bits.
  function automatic int unsigned popcount(input port_vec_t vec);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (vec[i]) c = c + 1;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tag_freelist_compact.sv
`default_nettype none
// ============================================================================
// Module      : tag_freelist_compact
// Description : Compacts the accepted release ports into consecutive write
//               offsets (in port order) and reports the accepted count.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_freelist_compact
  import tag_freelist_pkg::*;
#(
  parameter int REL_PORTS = REL_PORTS_DEF
) (
  input  logic [REL_PORTS-1:0]       rel_vld,
  input  logic [REL_PORTS-1:0]       accept_mask,
  output logic [REL_PORTS*OFF_W-1:0] wr_off,
  output logic [OFF_W-1:0]           rel_count
);

  logic [REL_PORTS-1:0] keep;
  logic [OFF_W-1:0]     run_cnt;

  assign keep = rel_vld & accept_mask;

  // Running sum: each kept port writes at the number of kept ports below it.
  always_comb begin
    wr_off  = '0;
    run_cnt = '0;
    for (int k = 0; k < REL_PORTS; k++) begin
      wr_off[k*OFF_W +: OFF_W] = run_cnt;
      run_cnt = run_cnt + OFF_W'(keep[k]);
    end
    rel_count = run_cnt;
  end

endmodule
`default_nettype wire

// File: rtl/tag_freelist_mp.sv
`default_nettype none
// ============================================================================
// Module      : tag_freelist_mp
// Description : Multi-port free list of rename tags held in a circular
//               buffer. Up to ALLOC_PORTS show-ahead allocations and up to
//               REL_PORTS releases per cycle, count-based status and sticky
//               error flags. Define TAG_FREELIST_DUPCHK_EN to add a free
//               bitmap that filters duplicate / out-of-range releases.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_freelist_mp
  import tag_freelist_pkg::*;
#(
  parameter int TAG_W       = TAG_W_DEF,
  parameter int NUM_TAGS    = NUM_TAGS_DEF,
  parameter int ALLOC_PORTS = ALLOC_PORTS_DEF,
  parameter int REL_PORTS   = REL_PORTS_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ALLOC_PORTS-1:0]         alloc_req,
  output logic [ALLOC_PORTS-1:0]         alloc_vld,
  output logic [ALLOC_PORTS*TAG_W-1:0]   alloc_tag,
  input  logic [REL_PORTS-1:0]           rel_vld,
  input  logic [REL_PORTS*TAG_W-1:0]     rel_tag,
  output logic [$clog2(NUM_TAGS+1)-1:0]  free_count,
  output logic                           fifo_empty,
  output logic                           fifo_full,
  output logic                           err_order,
  output logic                           err_ovf,
  output logic                           err_dup
);

  localparam int PTR_W = $clog2(NUM_TAGS);
  localparam int CNT_W = $clog2(NUM_TAGS + 1);

  logic [TAG_W-1:0]           storage_q [NUM_TAGS];
  logic [TAG_W-1:0]           storage_d [NUM_TAGS];
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]           free_count_q, free_count_d;
  logic                       full_q, full_d;
  logic                       empty_q, empty_d;
  logic                       err_order_q, err_order_d;
  logic                       err_ovf_q, err_ovf_d;

  logic [OFF_W-1:0]           grant_cnt;
  logic [REL_PORTS-1:0]       rel_mask;
  logic [REL_PORTS*OFF_W-1:0] rel_off;
  logic [OFF_W-1:0]           rel_cnt_raw;
  logic [REL_PORTS-1:0]       rel_accept;
  logic [CNT_W-1:0]           room;
  logic [CNT_W-1:0]           acc_cnt;

  // Show-ahead offer: driven from registered state only, never alloc_req.
  always_comb begin
    alloc_vld = '0;
    alloc_tag = '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      alloc_vld[i] = (32'(free_count_q) > unsigned'(i));
      alloc_tag[i*TAG_W +: TAG_W] =
        storage_q[PTR_W'(wrap_add(32'(rd_ptr_q), unsigned'(i), NUM_TAGS))];
    end
  end

  // Grant the contiguous prefix of requests that have a tag on offer; any
  // request above the first zero of alloc_req is a protocol error.
  always_comb begin
    grant_cnt   = OFF_W'(leading_ones(port_vec_t'(alloc_req & alloc_vld)));
    err_order_d = err_order_q |
                  (popcount(port_vec_t'(alloc_req)) !=
                   leading_ones(port_vec_t'(alloc_req)));
  end

`ifdef TAG_FREELIST_DUPCHK_EN
  logic [NUM_TAGS-1:0] free_q, free_d;
  logic                err_dup_q, err_dup_d;
  logic [TAG_W-1:0]    chk_tag;

  // Reject releases of already-free, out-of-range, or same-cycle repeated
  // tags (the earlier port keeps the tag) before they reach compaction.
  always_comb begin
    rel_mask = '1;
    chk_tag  = '0;
    for (int k = 0; k < REL_PORTS; k++) begin
      chk_tag = rel_tag[k*TAG_W +: TAG_W];
      if (32'(chk_tag) >= NUM_TAGS) begin
        rel_mask[k] = 1'b0;
      end else if (free_q[PTR_W'(chk_tag)]) begin
        rel_mask[k] = 1'b0;
      end
      for (int j = 0; j < k; j++) begin
        if (rel_vld[j] && (rel_tag[j*TAG_W +: TAG_W] == chk_tag)) begin
          rel_mask[k] = 1'b0;
        end
      end
    end
    err_dup_d = err_dup_q | (|(rel_vld & ~rel_mask));
  end

  // Bitmap tracks which tags sit in the list: granted tags leave, accepted
  // releases return.
  always_comb begin
    free_d = free_q;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      if (unsigned'(i) < 32'(grant_cnt)) begin
        free_d[PTR_W'(alloc_tag[i*TAG_W +: TAG_W])] = 1'b0;
      end
    end
    for (int k = 0; k < REL_PORTS; k++) begin
      if (rel_accept[k]) begin
        free_d[PTR_W'(rel_tag[k*TAG_W +: TAG_W])] = 1'b1;
      end
    end
  end

  // Bitmap and duplicate-error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_q    <= '1;
      err_dup_q <= 1'b0;
    end else begin
      free_q    <= free_d;
      err_dup_q <= err_dup_d;
    end
  end

  assign err_dup = err_dup_q;
`else
  assign rel_mask = '1;
  assign err_dup  = 1'b0;
`endif

  tag_freelist_compact #(
    .REL_PORTS (REL_PORTS)
  ) u_compact (
    .rel_vld     (rel_vld),
    .accept_mask (rel_mask),
    .wr_off      (rel_off),
    .rel_count   (rel_cnt_raw)
  );

  // Releases fill only the slots not currently holding a free tag; the
  // highest-numbered excess releases are dropped.
  always_comb begin
    room       = CNT_W'(NUM_TAGS) - free_count_q;
    rel_accept = '0;
    for (int k = 0; k < REL_PORTS; k++) begin
      rel_accept[k] = rel_vld[k] & rel_mask[k] &
                      (32'(rel_off[k*OFF_W +: OFF_W]) < 32'(room));
    end
    acc_cnt   = (32'(rel_cnt_raw) > 32'(room)) ? room : CNT_W'(rel_cnt_raw);
    err_ovf_d = err_ovf_q | (32'(rel_cnt_raw) > 32'(room));
  end

  // Storage writes, pointer advance and registered status.
  always_comb begin
    storage_d = storage_q;
    for (int k = 0; k < REL_PORTS; k++) begin
      if (rel_accept[k]) begin
        storage_d[PTR_W'(wrap_add(32'(wr_ptr_q),
                                  32'(rel_off[k*OFF_W +: OFF_W]),
                                  NUM_TAGS))] = rel_tag[k*TAG_W +: TAG_W];
      end
    end
    rd_ptr_d     = PTR_W'(wrap_add(32'(rd_ptr_q), 32'(grant_cnt), NUM_TAGS));
    wr_ptr_d     = PTR_W'(wrap_add(32'(wr_ptr_q), 32'(acc_cnt), NUM_TAGS));
    free_count_d = free_count_q - CNT_W'(grant_cnt) + acc_cnt;
    full_d       = (free_count_d == CNT_W'(NUM_TAGS));
    empty_d      = (free_count_d == '0);
  end

  // State registers; reset reloads the identity tag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        storage_q[i] <= TAG_W'(i);
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      free_count_q <= CNT_W'(NUM_TAGS);
      full_q       <= 1'b1;
      empty_q      <= 1'b0;
      err_order_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      storage_q    <= storage_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      free_count_q <= free_count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      err_order_q  <= err_order_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign free_count = free_count_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign err_order  = err_order_q;
  assign err_ovf    = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_tag_freelist_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_tag_freelist_mp
// Description : Self-checking bench for tag_freelist_mp. Two instances
//               (64 and 48 tags) share one directed stimulus stream; a
//               queue-based free-list model per instance is compared every
//               cycle, and literal expectations pin key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tag_freelist_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  alloc_req = '0;
  logic [1:0]  rel_vld   = '0;
  logic [11:0] rel_tag   = '0;

  logic [1:0]  vld0, vld1;
  logic [11:0] tag0, tag1;
  logic [6:0]  cnt0;
  logic [5:0]  cnt1;
  logic        empty0, full0, eo0, ev0, ed0;
  logic        empty1, full1, eo1, ev1, ed1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk   = 1'b0;

  always #5 clk = ~clk;

  tag_freelist_mp #(.TAG_W(6), .NUM_TAGS(64), .ALLOC_PORTS(2), .REL_PORTS(2)) dut0 (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_vld(vld0), .alloc_tag(tag0),
    .rel_vld(rel_vld), .rel_tag(rel_tag), .free_count(cnt0), .fifo_empty(empty0),
    .fifo_full(full0), .err_order(eo0), .err_ovf(ev0), .err_dup(ed0));

  tag_freelist_mp #(.TAG_W(6), .NUM_TAGS(48), .ALLOC_PORTS(2), .REL_PORTS(2)) dut1 (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_vld(vld1), .alloc_tag(tag1),
    .rel_vld(rel_vld), .rel_tag(rel_tag), .free_count(cnt1), .fifo_empty(empty1),
    .fifo_full(full1), .err_order(eo1), .err_ovf(ev1), .err_dup(ed1));

  // ---------------- behavioural model: ordered queue of free tags ----------
  int unsigned mq [2][$];
  bit          mfree [2][64];
  bit          m_eo [2];
  bit          m_ev [2];
  bit          m_ed [2];

  function automatic int unsigned nt(input int d);
    return (d == 0) ? 64 : 48;
  endfunction

  task automatic model_reset(input int d);
    mq[d].delete();
    for (int t = 0; t < 64; t++) begin
      if (t < nt(d)) mq[d].push_back(t);
      mfree[d][t] = (t < nt(d));
    end
    m_eo[d] = 1'b0;
    m_ev[d] = 1'b0;
    m_ed[d] = 1'b0;
  endtask

  task automatic model_step(input int d);
    int unsigned n, sz, lead, ones, g, room, t;
    bit          drop;
    int unsigned acc[$];
    n    = nt(d);
    sz   = mq[d].size();
    ones = 0;
    for (int i = 0; i < 2; i++) if (alloc_req[i]) ones++;
    lead = (alloc_req[0] == 1'b0) ? 0 : ((alloc_req[1] == 1'b0) ? 1 : 2);
    if (ones != lead) m_eo[d] = 1'b1;
    g = (lead < sz) ? lead : sz;
    for (int k = 0; k < 2; k++) begin
      if (rel_vld[k]) begin
        t    = rel_tag[k*6 +: 6];
        drop = 1'b0;
`ifdef TAG_FREELIST_DUPCHK_EN
        drop = (t >= n) || mfree[d][t] ||
               ((k == 1) && rel_vld[0] && (rel_tag[5:0] == t[5:0]));
        if (drop) m_ed[d] = 1'b1;
`endif
        if (!drop) acc.push_back(t);
      end
    end
    room = n - sz;
    if (acc.size() > room) begin
      m_ev[d] = 1'b1;
      while (acc.size() > room) acc.pop_back();
    end
    for (int i = 0; i < int'(g); i++) begin
      t = mq[d].pop_front();
      mfree[d][t] = 1'b0;
    end
    foreach (acc[j]) begin
      mq[d].push_back(acc[j]);
      mfree[d][acc[j]] = 1'b1;
    end
  endtask

  // Model advances on the same edge as the DUTs.
  always @(posedge clk) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- comparison helpers -------------------------------------
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic [6:0] cnt, input logic [1:0] vld,
                           input logic [11:0] tags, input logic full, input logic empty,
                           input logic eo, input logic ev, input logic ed);
    int unsigned sz;
    string       p;
    sz = mq[d].size();
    p  = (d == 0) ? "n64" : "n48";
    cmp({p, ".free_count"}, 32'(cnt), sz);
    for (int i = 0; i < 2; i++) begin
      cmp($sformatf("%s.alloc_vld%0d", p, i), 32'(vld[i]), (unsigned'(i) < sz) ? 1 : 0);
      if (unsigned'(i) < sz)
        cmp($sformatf("%s.alloc_tag%0d", p, i), 32'(tags[i*6 +: 6]), mq[d][i]);
    end
    cmp({p, ".fifo_full"},  32'(full),  (sz == nt(d)) ? 1 : 0);
    cmp({p, ".fifo_empty"}, 32'(empty), (sz == 0) ? 1 : 0);
    cmp({p, ".err_order"},  32'(eo), 32'(m_eo[d]));
    cmp({p, ".err_ovf"},    32'(ev), 32'(m_ev[d]));
    cmp({p, ".err_dup"},    32'(ed), 32'(m_ed[d]));
  endtask

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk) begin
      check_dut(0, cnt0, vld0, tag0, full0, empty0, eo0, ev0, ed0);
      check_dut(1, 7'(cnt1), vld1, tag1, full1, empty1, eo1, ev1, ed1);
    end
  end

  // ---------------- directed stimulus --------------------------------------
  task automatic drive(input logic [1:0] req, input logic [1:0] rv, input logic [11:0] tg);
    alloc_req = req;
    rel_vld   = rv;
    rel_tag   = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] req, input logic [1:0] rv);
    rst       = 1'b1;
    alloc_req = req;
    rel_vld   = rv;
    rel_tag   = {6'd2, 6'd1};
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    chk = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    cmp("rst.free_count", 32'(cnt0), 64);
    cmp("rst.alloc_vld",  32'(vld0), 3);
    cmp("rst.alloc_tag",  32'(tag0), 32'h040);
    cmp("rst.fifo_full",  32'(full0), 1);
    cmp("rst.n48_count",  32'(cnt1), 48);

    // Drain both lists two tags per cycle
    for (int i = 0; i < 32; i++) begin
      if (i == 23) cmp("n48.wrap_offer", 32'(tag1), {6'd47, 6'd46});
      if (i == 31) cmp("n64.last_offer", 32'(tag0), {6'd63, 6'd62});
      drive(2'b11, 2'b00, '0);
    end
    cmp("drain.empty", 32'(empty0), 1);
    cmp("drain.vld",   32'(vld0), 0);
    cmp("drain.count", 32'(cnt0), 0);

    // Release 5 and 9 into empty lists: no bypass in the release cycle
    cmp("rel.vld_same_cycle", 32'(vld0), 0);
    drive(2'b11, 2'b11, {6'd9, 6'd5});
    cmp("rel.tags", 32'(tag0), {6'd9, 6'd5});
    cmp("rel.count", 32'(cnt0), 2);
    cmp("rel.n48_tags_after_wrap", 32'(tag1), {6'd9, 6'd5});

    // Bring to one free tag, then partial grant with concurrent release
    drive(2'b01, 2'b00, '0);
    drive(2'b11, 2'b01, {6'd0, 6'd7});
    cmp("part.count", 32'(cnt0), 1);
    cmp("part.tag0",  32'(tag0[5:0]), 7);
    cmp("part.no_order_err", 32'(eo0), 0);

    // Non-prefix request
    drive(2'b10, 2'b00, '0);
    cmp("order.err",   32'(eo0), 1);
    cmp("order.count", 32'(cnt0), 1);
    drive(2'b00, 2'b00, '0);
    cmp("order.sticky", 32'(eo0), 1);

    // Reset mid-operation with live inputs
    do_reset(2'b11, 2'b11);
    cmp("rst2.count", 32'(cnt0), 64);
    cmp("rst2.err_order", 32'(eo0), 0);
    cmp("rst2.tags", 32'(tag0), 32'h040);

    // Release into a full list
    drive(2'b00, 2'b01, {6'd0, 6'd3});
    cmp("full_rel.count", 32'(cnt0), 64);
`ifdef TAG_FREELIST_DUPCHK_EN
    cmp("full_rel.err_dup", 32'(ed0), 1);
    cmp("full_rel.err_ovf", 32'(ev0), 0);
`else
    cmp("full_rel.err_ovf", 32'(ev0), 1);
    cmp("full_rel.err_dup", 32'(ed0), 0);
`endif

    // Release of a tag still in the list (12)
    do_reset(2'b00, 2'b00);
    drive(2'b11, 2'b00, '0);
    drive(2'b00, 2'b01, {6'd0, 6'd12});
`ifdef TAG_FREELIST_DUPCHK_EN
    cmp("dup12.count", 32'(cnt0), 62);
    cmp("dup12.err_dup", 32'(ed0), 1);
`else
    cmp("dup12.count", 32'(cnt0), 63);
`endif

    // Two copies of allocated tag 20 in one cycle
    do_reset(2'b00, 2'b00);
    for (int i = 0; i < 11; i++) drive(2'b11, 2'b00, '0);
    cmp("pair.pre_count", 32'(cnt0), 42);
    drive(2'b00, 2'b11, {6'd20, 6'd20});
`ifdef TAG_FREELIST_DUPCHK_EN
    cmp("pair.count", 32'(cnt0), 43);
    cmp("pair.err_dup", 32'(ed0), 1);
`else
    cmp("pair.count", 32'(cnt0), 44);
`endif

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 40; i++) begin
      drive(2'(i % 4), 2'((i * 3) % 4), {6'((i * 11 + 3) % 64), 6'((i * 7) % 64)});
    end
    drive(2'b00, 2'b00, '0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
